// File: rtl/bqcoefctl.sv
// rtl/bqcoefctl.sv - biquad coefficient shadow/active bank commit controller
module bqcoefctl #(
   parameter int COEFWIDTH = 8,
   parameter int SETTLE    = 4,
   parameter int CNTWIDTH  = 16
) (
   input  logic                 dspclk,
   input  logic                 nreset,
   input  logic                 wr_en,
   input  logic [2:0]           wr_addr,
   input  logic [15:0]          wr_data,
   output logic                 wr_err,
   input  logic                 commit_req,
   output logic                 commit_busy,
   output logic                 commit_done,
   input  logic                 valid_in,
   output logic                 valid_out,
   output logic [COEFWIDTH-1:0] a11,
   output logic [COEFWIDTH-1:0] a12,
   output logic [COEFWIDTH-1:0] b10,
   output logic [COEFWIDTH-1:0] b11,
   output logic [COEFWIDTH-1:0] b12,
   output logic [CNTWIDTH-1:0]  smp_cnt
);

   // Settle counter only has to hold SETTLE-1.
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] RELOAD = SW'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_WAIT  = 2'd2,
      ST_SWAP  = 2'd3
   } state_t;

   state_t        state;
   logic [SW-1:0] cnt;
   logic [15:0]   shadow [5];
   logic          wr_ok;

   // Shadow is only writable while no commit is pending.
   assign wr_ok       = wr_en && (state == ST_IDLE) && (wr_addr <= 3'd4);
   assign commit_busy = (state != ST_IDLE);

   // Commit FSM: arm on request, wait for a quiet gap of SETTLE cycles after a sample, then swap.
   always_ff @(posedge dspclk or negedge nreset) begin
      if (!nreset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         commit_done <= 1'b0;
      end else begin
         commit_done <= (state == ST_SWAP);
         case (state)
            ST_IDLE: begin
               if (commit_req) state <= ST_ARMED;
            end
            ST_ARMED: begin
               if (valid_in) begin
                  state <= ST_WAIT;
                  cnt   <= RELOAD;
               end
            end
            ST_WAIT: begin
               if (valid_in)        cnt   <= RELOAD;
               else if (cnt == '0)  state <= ST_SWAP;
               else                 cnt   <= cnt - 1'b1;
            end
            ST_SWAP: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Shadow bank writes and reject pulse for writes outside IDLE or to a bad address.
   always_ff @(posedge dspclk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < 5; i++) shadow[i] <= '0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && !wr_ok;
         for (int i = 0; i < 5; i++) begin
            if (wr_ok && (wr_addr == 3'(i))) shadow[i] <= wr_data;
         end
      end
   end

   // Active bank: all five coefficients move together, MSB-truncated, only in SWAP.
   always_ff @(posedge dspclk or negedge nreset) begin
      if (!nreset) begin
         a11 <= '0;
         a12 <= '0;
         b10 <= '0;
         b11 <= '0;
         b12 <= '0;
      end else if (state == ST_SWAP) begin
         a11 <= shadow[0][15:16-COEFWIDTH];
         a12 <= shadow[1][15:16-COEFWIDTH];
         b10 <= shadow[2][15:16-COEFWIDTH];
         b11 <= shadow[3][15:16-COEFWIDTH];
         b12 <= shadow[4][15:16-COEFWIDTH];
      end
   end

   // Sample strobe delay toward the filter; never gated.
   always_ff @(posedge dspclk or negedge nreset) begin
      if (!nreset) valid_out <= 1'b0;
      else         valid_out <= valid_in;
   end

   // Saturating count of samples seen since the last swap; the swap clear takes priority.
   always_ff @(posedge dspclk or negedge nreset) begin
      if (!nreset)                          smp_cnt <= '0;
      else if (state == ST_SWAP)            smp_cnt <= '0;
      else if (valid_out && smp_cnt != '1)  smp_cnt <= smp_cnt + 1'b1;
   end

endmodule

// File: tb/tb_bqcoefctl.sv
// tb/tb_bqcoefctl.sv - self-checking bench for bqcoefctl
module tb_bqcoefctl;

   logic        dspclk = 1'b0;
   logic        nreset;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_err;
   logic        commit_req;
   logic        commit_busy;
   logic        commit_done;
   logic        valid_in;
   logic        valid_out;
   logic [7:0]  a11, a12, b10, b11, b12;
   logic [15:0] smp_cnt;
   logic [39:0] coef;

   int total  = 0;
   int passed = 0;

   assign coef = {a11, a12, b10, b11, b12};

   always #5 dspclk = ~dspclk;

   bqcoefctl #(.COEFWIDTH(8), .SETTLE(4), .CNTWIDTH(16)) dut (
      .dspclk(dspclk), .nreset(nreset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
      .commit_req(commit_req), .commit_busy(commit_busy), .commit_done(commit_done),
      .valid_in(valid_in), .valid_out(valid_out),
      .a11(a11), .a12(a12), .b10(b10), .b11(b11), .b12(b12),
      .smp_cnt(smp_cnt)
   );

   typedef struct {
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        req;
      logic        vin;
      logic        e_err;
      logic        e_busy;
      logic        e_done;
      logic        e_vout;
      logic [15:0] e_smp;
      logic [39:0] e_coef;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic step();
      @(posedge dspclk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0; commit_req = 1'b0; valid_in = 1'b0;
   endtask

   function automatic logic [39:0] trunc5(input logic [15:0] v0, input logic [15:0] v1,
                                          input logic [15:0] v2, input logic [15:0] v3,
                                          input logic [15:0] v4);
      return {v0[15:8], v1[15:8], v2[15:8], v3[15:8], v4[15:8]};
   endfunction

   initial begin
      logic [39:0] old_c, new_c;
      logic [15:0] rv [5];
      int n, dones;
      bit seen;

      idle_inputs();
      nreset = 1'b0;
      step(); step();
      check("rst_busy", 64'(commit_busy), 64'(1'b0));
      check("rst_coef", 64'(coef), 64'(40'h0));
      check("rst_smp", 64'(smp_cnt), 64'(16'h0));
      nreset = 1'b1;
      step();

      // load five coefficients, commit, one sample, swap
      tbl[0]  = '{1'b1, 3'd0, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 40'h0};
      tbl[1]  = '{1'b1, 3'd1, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 40'h0};
      tbl[2]  = '{1'b1, 3'd2, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 40'h0};
      tbl[3]  = '{1'b1, 3'd3, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 40'h0};
      tbl[4]  = '{1'b1, 3'd4, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 40'h0};
      tbl[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 40'h0};
      tbl[6]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 40'h0};
      tbl[7]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 40'h0};
      tbl[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 40'h0};
      tbl[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 40'h0};
      tbl[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 40'h40C0204020};
      tbl[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 40'h40C0204020};
      tbl[12] = '{1'b1, 3'd6, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 40'h40C0204020};
      tbl[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 40'h40C0204020};

      for (int i = 0; i < 14; i++) begin
         wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
         commit_req = tbl[i].req; valid_in = tbl[i].vin;
         step();
         check($sformatf("v%0d_err", i),  64'(wr_err),      64'(tbl[i].e_err));
         check($sformatf("v%0d_busy", i), 64'(commit_busy), 64'(tbl[i].e_busy));
         check($sformatf("v%0d_done", i), 64'(commit_done), 64'(tbl[i].e_done));
         check($sformatf("v%0d_vout", i), 64'(valid_out),   64'(tbl[i].e_vout));
         check($sformatf("v%0d_smp", i),  64'(smp_cnt),     64'(tbl[i].e_smp));
         check($sformatf("v%0d_coef", i), 64'(coef),        64'(tbl[i].e_coef));
      end
      idle_inputs();

      // write b10, commit, rejected write while armed, valids every 2 cycles hold off the swap
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h7F00;
      step();
      check("b2b_wr_ok", 64'(wr_err), 64'(1'b0));
      idle_inputs(); commit_req = 1'b1;
      step();
      idle_inputs(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1100;
      step();
      check("busy_wr_err", 64'(wr_err), 64'(1'b1));
      idle_inputs();
      for (int i = 0; i < 10; i++) begin
         valid_in = 1'b1;
         step();
         check("b2b_vout", 64'(valid_out), 64'(1'b1));
         valid_in = 1'b0;
         step();
         check("b2b_busy", 64'(commit_busy), 64'(1'b1));
         check("b2b_hold", 64'(coef), 64'(40'h40C0204020));
      end
      n = 0; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(); n++;
         if (commit_done) seen = 1;
      end
      check("b2b_seen", 64'(seen), 64'(1'b1));
      check("b2b_lat", 64'(n), 64'(4));
      check("b2b_coef", 64'(coef), 64'(40'h40C07F4020));
      check("b2b_smp", 64'(smp_cnt), 64'(16'd0));

      // extra commit requests while busy yield exactly one done
      commit_req = 1'b1; step();
      commit_req = 1'b0; valid_in = 1'b1; step();
      valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         commit_req = 1'b1; step();
         check("mreq_busy", 64'(commit_busy), 64'(1'b1));
      end
      commit_req = 1'b0;
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (commit_done) dones++;
      end
      check("mreq_dones", 64'(dones), 64'(1));
      check("mreq_busy_end", 64'(commit_busy), 64'(1'b0));

      // random coefficient sets: biquad view on each sample is entirely old or entirely new
      old_c = coef;
      for (int r = 0; r < 5; r++) begin
         for (int a = 0; a < 5; a++) begin
            rv[a] = 16'($urandom);
            wr_en = 1'b1; wr_addr = 3'(a); wr_data = rv[a];
            step();
         end
         new_c = trunc5(rv[0], rv[1], rv[2], rv[3], rv[4]);
         wr_en = 1'b0; commit_req = 1'b1;
         step();
         commit_req = 1'b0;
         seen = 0;
         for (int i = 0; i < 400 && !seen; i++) begin
            valid_in = (i < 100) && ($urandom_range(0, 2) == 0);
            step();
            if (valid_out) check("rnd_atomic", 64'((coef == old_c) || (coef == new_c)), 64'(1'b1));
            if (commit_done) seen = 1;
         end
         valid_in = 1'b0;
         check("rnd_done", 64'(seen), 64'(1'b1));
         check("rnd_coef", 64'(coef), 64'(new_c));
         old_c = new_c;
      end

      // reset in the middle of WAIT abandons the commit
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h5500; step();
      wr_en = 1'b0; commit_req = 1'b1; step();
      commit_req = 1'b0; valid_in = 1'b1; step();
      valid_in = 1'b0; step(); step();
      check("mid_busy", 64'(commit_busy), 64'(1'b1));
      #2 nreset = 1'b0;
      #1;
      check("ar_busy", 64'(commit_busy), 64'(1'b0));
      check("ar_coef", 64'(coef), 64'(40'h0));
      check("ar_misc", 64'({wr_err, commit_done, valid_out}), 64'(3'b000));
      check("ar_smp", 64'(smp_cnt), 64'(16'd0));
      step();
      nreset = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (commit_done || commit_busy) dones++;
      end
      check("ar_no_done", 64'(dones), 64'(0));
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h3300; step();
      wr_en = 1'b0;
      check("ar_idle_wr", 64'(wr_err), 64'(1'b0));
      check("ar_coef_keep", 64'(coef), 64'(40'h0));

      // smp_cnt saturates at all-ones
      valid_in = 1'b1;
      repeat (65540) step();
      check("sat_max", 64'(smp_cnt), 64'(16'hFFFF));
      repeat (4) step();
      valid_in = 1'b0;
      step(); step();
      check("sat_hold", 64'(smp_cnt), 64'(16'hFFFF));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
